// File: rtl/prog_loader.sv
`timescale 1ns/1ps
// Instruction-memory loader: assembles a framed big-endian byte stream into
// 32-bit words for the CPU write port and gates cpu_en until a clean load.
module prog_loader #(
  parameter int unsigned ADRS_W       = 11,
  parameter int unsigned TIMEOUT      = 1024,
  parameter bit          RUN_AT_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_req,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [31:0]       w_instruction,
  output logic              w_enable,
  output logic [ADRS_W-1:0] w_adrs,
  output logic              cpu_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, AHI, ALO, CHI, CLO, DATA, DONE} state_t;

  state_t            state, state_nx;
  logic [ADRS_W-1:0] addr;
  logic [15:0]       count;
  logic [23:0]       shreg;
  logic [1:0]        bidx;
  logic [15:0]       tmo_cnt;
  logic              accept, start, abort, finish, wr_end;

  // w_enable doubles as the write-cycle flag, so no byte is taken while a word is written
  always_comb begin
    rx_ready = 1'b0;
    case (state)
      AHI, ALO, CHI, CLO: rx_ready = 1'b1;
      DATA:               rx_ready = !w_enable && (count != '0);
      default:            rx_ready = 1'b0;
    endcase
  end

  assign accept = rx_valid & rx_ready;
  assign busy   = (state != IDLE) && (state != DONE);

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    abort    = 1'b0;
    finish   = 1'b0;
    wr_end   = 1'b0;
    case (state)
      IDLE, DONE: if (load_req) begin start = 1'b1; state_nx = AHI; end
      AHI:        if (accept) state_nx = ALO;
      ALO:        if (accept) state_nx = CHI;
      CHI:        if (accept) state_nx = CLO;
      CLO:        if (accept) state_nx = DATA;
      DATA: begin
        if (count == '0) begin
          finish   = 1'b1;
          state_nx = DONE;
        end else if (w_enable) begin
          wr_end = 1'b1;
          if (count == 16'd1) begin
            finish   = 1'b1;
            state_nx = DONE;
          end else if (&addr) begin
            // top address just written with words still pending: never wrap
            abort    = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (busy && !accept && !finish && tmo_cnt == TMO_LAST) begin
      abort    = 1'b1;
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      addr          <= '0;
      count         <= '0;
      shreg         <= '0;
      bidx          <= '0;
      tmo_cnt       <= '0;
      w_instruction <= '0;
      w_enable      <= 1'b0;
      w_adrs        <= '0;
      cpu_en        <= RUN_AT_RESET;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state    <= state_nx;
      w_enable <= 1'b0;
      if (start) begin
        tmo_cnt <= '0;
        bidx    <= '0;
        cpu_en  <= 1'b0;
        done    <= 1'b0;
        err     <= 1'b0;
      end else if (busy) begin
        tmo_cnt <= accept ? '0 : tmo_cnt + 16'd1;
      end
      if (accept) begin
        case (state)
          AHI: addr[ADRS_W-1:8] <= rx_data[ADRS_W-9:0];
          ALO: addr[7:0]        <= rx_data;
          CHI: count[15:8]      <= rx_data;
          CLO: count[7:0]       <= rx_data;
          DATA: begin
            shreg <= {shreg[15:0], rx_data};
            bidx  <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              w_enable      <= 1'b1;
              w_instruction <= {shreg, rx_data};
              w_adrs        <= addr;
            end
          end
          default: ;
        endcase
      end
      if (wr_end && !abort) begin
        addr  <= addr + ADRS_W'(1);
        count <= count - 16'd1;
      end
      if (finish) begin
        done   <= 1'b1;
        cpu_en <= 1'b1;
      end
      if (abort) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
// Scoreboard bench for prog_loader: frame-level reference model predicts the
// write list and outcome; a negedge monitor checks every w_enable strobe.
module tb_prog_loader;
  localparam int unsigned AW    = 11;
  localparam int unsigned TMO   = 16;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0, resetn = 1'b0, load_req = 1'b0, rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_ready, w_enable, cpu_en, busy, done, err;
  logic [31:0]   w_instruction;
  logic [AW-1:0] w_adrs;

  prog_loader #(.ADRS_W(AW), .TIMEOUT(TMO), .RUN_AT_RESET(1'b0)) dut (
    .clk(clk), .resetn(resetn), .load_req(load_req),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .w_instruction(w_instruction), .w_enable(w_enable), .w_adrs(w_adrs),
    .cpu_en(cpu_en), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
    int unsigned   c;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] word_src[$];
  int unsigned n_cmp = 0, n_bad = 0;
  bit          gaps = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest predicted write
  always @(negedge clk) begin
    wr_t e;
    #1;
    if (w_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: w_enable=1 adrs=0x%0h data=0x%0h, expected no write (cycle %0d)",
                 w_adrs, w_instruction, cyc);
      end else begin
        e = exp_q.pop_front();
        check("w_adrs", 32'(w_adrs), 32'(e.a));
        check("w_instruction", w_instruction, e.d);
        check("w_enable_cycle", cyc, e.c);
      end
    end
  end

  // Called at a negedge; returns at the negedge following acceptance
  task automatic send_byte(input logic [7:0] b, output int unsigned acc);
    bit ok = 1'b0;
    acc = 0;
    if (gaps) begin
      int unsigned g = $urandom_range(0, 3);
      repeat (g) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (rx_ready === 1'b1) begin
        acc = cyc;
        ok  = 1'b1;
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL byte_accept: rx_ready low for 40 cycles on byte 0x%0h, expected acceptance", b);
    end
  endtask

  task automatic pulse_load;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic send_header(input logic [AW-1:0] st, input logic [15:0] nn, output int unsigned acc);
    logic [7:0] hi;
    hi = 8'($urandom);
    hi[AW-9:0] = st[AW-1:8];
    send_byte(hi, acc);
    send_byte(st[7:0], acc);
    send_byte(nn[15:8], acc);
    send_byte(nn[7:0], acc);
  endtask

  // Reference: min(N, DEPTH-start) sequential writes; clean only if all fit
  task automatic run_frame(input logic [AW-1:0] st, input int unsigned n, input bit mid_req);
    int unsigned avail = DEPTH - st;
    int unsigned nw    = (n < avail) ? n : avail;
    bit          ovr   = (n > avail);
    int unsigned acc, last;
    logic [31:0] w;
    logic [7:0]  bb;
    wr_t         e;
    pulse_load();
    check("start_busy", 32'(busy), 32'(1));
    check("start_done", 32'(done), 32'(0));
    check("start_err", 32'(err), 32'(0));
    check("start_cpu_en", 32'(cpu_en), 32'(0));
    send_header(st, 16'(n), last);
    for (int unsigned k = 0; k < nw; k++) begin
      w = (word_src.size() > 0) ? word_src.pop_front() : $urandom;
      if (mid_req && k == 0) pulse_load();
      for (int j = 3; j >= 0; j--) begin
        bb = w[j*8 +: 8];
        send_byte(bb, acc);
      end
      e.a = st + AW'(k);
      e.d = w;
      e.c = acc + 1;
      exp_q.push_back(e);
      last = acc;
    end
    if (n > 0) check("done_early", 32'(done), 32'(0));
    @(negedge clk);
    check("end_done", 32'(done), 32'(!ovr));
    check("end_err", 32'(err), 32'(ovr));
    check("end_cpu_en", 32'(cpu_en), 32'(!ovr));
    check("end_busy", 32'(busy), 32'(0));
    check("end_cycle", cyc, last + 2);
    check("writes_outstanding", exp_q.size(), 32'(0));
  endtask

  task automatic timeout_test;
    int unsigned acc, first = 0;
    bit seen = 1'b0;
    pulse_load();
    send_header(11'h010, 16'd2, acc);
    send_byte(8'hC3, acc);
    send_byte(8'h5A, acc);
    for (int i = 0; i < 3 * TMO && !seen; i++) begin
      if (err === 1'b1) begin
        seen  = 1'b1;
        first = cyc;
      end else begin
        @(negedge clk);
      end
    end
    check("timeout_cycle", first, acc + TMO + 1);
    check("timeout_done", 32'(done), 32'(0));
    check("timeout_cpu_en", 32'(cpu_en), 32'(0));
    check("timeout_busy", 32'(busy), 32'(0));
    check("timeout_rx_ready", 32'(rx_ready), 32'(0));
    check("timeout_writes", exp_q.size(), 32'(0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'(0));
    check({tag, "_w_enable"}, 32'(w_enable), 32'(0));
    check({tag, "_w_instruction"}, w_instruction, 32'(0));
    check({tag, "_w_adrs"}, 32'(w_adrs), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_err"}, 32'(err), 32'(0));
    check({tag, "_cpu_en"}, 32'(cpu_en), 32'(0));
  endtask

  task automatic reset_mid_data;
    int unsigned acc;
    pulse_load();
    send_header(11'h005, 16'd2, acc);
    send_byte(8'h12, acc);
    send_byte(8'h34, acc);
    resetn = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    check("midrst_next_rx_ready", 32'(rx_ready), 32'(0));
    check("midrst_next_busy", 32'(busy), 32'(0));
    check("midrst_next_cpu_en", 32'(cpu_en), 32'(0));
    @(negedge clk);
    resetn = 1'b1;
    repeat (8) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    check("midrst_after_busy", 32'(busy), 32'(0));
    check("midrst_after_writes", exp_q.size(), 32'(0));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] st;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    resetn = 1'b1;
    @(negedge clk);
    check_reset_values("post_rst");

    word_src = '{32'h12345678, 32'hABCDEF01};
    gaps = 1'b0;
    run_frame(11'h001, 2, 1'b0);
    word_src = '{32'h12345678, 32'hABCDEF01};
    gaps = 1'b1;
    run_frame(11'h001, 2, 1'b0);

    run_frame(11'h7FE, 3, 1'b0);
    run_frame(11'h100, 0, 1'b0);

    timeout_test();
    run_frame(11'h020, 3, 1'b0);

    for (int i = 0; i < 12; i++) begin
      st = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(DEPTH - 4, DEPTH - 1)) : AW'($urandom);
      run_frame(st, $urandom_range(0, 5), ($urandom_range(0, 3) == 0));
    end

    reset_mid_data();
    run_frame(11'h003, 2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
